// File: rtl/systolic_mmu.sv
// Weight-stationary ARRAY_SIZE x ARRAY_SIZE systolic matrix unit, y[j] = sum_i x[i]*W[i][j].
// Shadow/active weight banks, input skew, output de-skew, fixed 2*ARRAY_SIZE latency.
module systolic_mmu #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int ARRAY_SIZE = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             w_valid,
    output logic                             w_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] w_data,
    input  logic                             w_signed,
    input  logic                             a_valid,
    output logic                             a_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] a_data,
    output logic                             out_valid,
    output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_data,
    output logic                             busy
);
    localparam int N  = ARRAY_SIZE;
    localparam int DW = DATA_WIDTH;
    localparam int AW = ACC_WIDTH;
    localparam int CW = $clog2(N);
    localparam int IW = $clog2(2 * N + 1);

    logic [N*DW-1:0] shadow_reg [N];
    logic [N*DW-1:0] active_reg [N];
    logic            shadow_signed_reg;
    logic            active_signed_reg;
    logic            active_valid_reg;
    logic            shadow_full_reg;
    logic [CW-1:0]   w_cnt_reg;
    logic [IW-1:0]   inflight_reg;
    logic [2*N-1:0]  vpipe_reg;

    logic w_fire;
    logic a_fire;
    logic swap;

    assign w_ready   = !shadow_full_reg && !rst;
    assign a_ready   = active_valid_reg && !shadow_full_reg && !rst;
    assign w_fire    = w_valid && w_ready;
    assign a_fire    = a_valid && a_ready;
    assign swap      = shadow_full_reg && (inflight_reg == '0);
    assign out_valid = vpipe_reg[2*N-1];
    assign busy      = (inflight_reg != '0);

    // Accepts and swaps are mutually exclusive, so the active bank never changes under a live vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                shadow_reg[i] <= '0;
                active_reg[i] <= '0;
            end
            shadow_signed_reg <= 1'b0;
            active_signed_reg <= 1'b0;
            active_valid_reg  <= 1'b0;
            shadow_full_reg   <= 1'b0;
            w_cnt_reg         <= '0;
            inflight_reg      <= '0;
            vpipe_reg         <= '0;
        end else begin
            if (w_fire) begin
                shadow_reg[w_cnt_reg] <= w_data;
                if (w_cnt_reg == '0)
                    shadow_signed_reg <= w_signed;
                if (w_cnt_reg == CW'(N - 1)) begin
                    w_cnt_reg       <= '0;
                    shadow_full_reg <= 1'b1;
                end else begin
                    w_cnt_reg <= w_cnt_reg + CW'(1);
                end
            end
            if (swap) begin
                for (int i = 0; i < N; i++)
                    active_reg[i] <= shadow_reg[i];
                active_signed_reg <= shadow_signed_reg;
                active_valid_reg  <= 1'b1;
                shadow_full_reg   <= 1'b0;
            end
            case ({a_fire, out_valid})
                2'b10:   inflight_reg <= inflight_reg + IW'(1);
                2'b01:   inflight_reg <= inflight_reg - IW'(1);
                default: inflight_reg <= inflight_reg;
            endcase
            vpipe_reg <= {vpipe_reg[2*N-2:0], a_fire};
        end
    end

    logic [DW-1:0] row_in  [N];
    logic [DW-1:0] act_q   [N][N-1];
    logic [AW-1:0] psum_q  [N][N];
    logic [AW-1:0] col_out [N];

    genvar gi, gj;

    // Row gi sees its element gi cycles later than row 0.
    for (gi = 0; gi < N; gi++) begin : g_skew
        logic [DW-1:0] sk_reg [gi+1];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= gi; k++)
                    sk_reg[k] <= '0;
            end else begin
                sk_reg[0] <= a_fire ? a_data[gi*DW +: DW] : '0;
                for (int k = 1; k <= gi; k++)
                    sk_reg[k] <= sk_reg[k-1];
            end
        end
        assign row_in[gi] = sk_reg[gi];
    end

    for (gi = 0; gi < N; gi++) begin : g_row
        for (gj = 0; gj < N; gj++) begin : g_col
            logic [DW-1:0] act_in;
            logic [DW-1:0] w_el;
            logic [AW-1:0] psum_in;
            logic [AW-1:0] a_ext;
            logic [AW-1:0] w_ext;
            logic [AW-1:0] prod;
            logic [DW-1:0] act_reg;
            logic [AW-1:0] psum_reg;

            if (gj == 0) begin : g_west
                assign act_in = row_in[gi];
            end else begin : g_inner
                assign act_in = act_q[gi][gj-1];
            end
            if (gi == 0) begin : g_top
                assign psum_in = '0;
            end else begin : g_below
                assign psum_in = psum_q[gi-1][gj];
            end

            // Extending both operands to ACC_WIDTH makes the low ACC_WIDTH product bits
            // correct for both signed and unsigned modes.
            assign w_el  = active_reg[gi][gj*DW +: DW];
            assign a_ext = {{(AW-DW){active_signed_reg & act_in[DW-1]}}, act_in};
            assign w_ext = {{(AW-DW){active_signed_reg & w_el[DW-1]}}, w_el};
            assign prod  = a_ext * w_ext;

            always_ff @(posedge clk) begin
                if (rst) begin
                    act_reg  <= '0;
                    psum_reg <= '0;
                end else begin
                    act_reg  <= act_in;
                    psum_reg <= psum_in + prod;
                end
            end

            if (gj < N - 1) begin : g_pass
                assign act_q[gi][gj] = act_reg;
            end
            assign psum_q[gi][gj] = psum_reg;
        end
    end

    // Column gj finishes gj cycles after column 0; pad it back into alignment.
    for (gj = 0; gj < N; gj++) begin : g_deskew
        localparam int D = N - 1 - gj;
        if (D == 0) begin : g_direct
            assign col_out[gj] = psum_q[N-1][gj];
        end else begin : g_delay
            logic [AW-1:0] ds_reg [D];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < D; k++)
                        ds_reg[k] <= '0;
                end else begin
                    ds_reg[0] <= psum_q[N-1][gj];
                    for (int k = 1; k < D; k++)
                        ds_reg[k] <= ds_reg[k-1];
                end
            end
            assign col_out[gj] = ds_reg[D-1];
        end
        assign out_data[gj*AW +: AW] = col_out[gj];
    end

endmodule

// File: tb/tb_systolic_mmu.sv
// Scoreboard bench for systolic_mmu: stimulus pushes expected vectors, a negedge monitor pops and compares.
module tb_systolic_mmu;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int VW = N * DW;
    localparam int OW = N * AW;

    typedef logic [N-1:0][VW-1:0] wmat_t;
    typedef struct {
        logic [OW-1:0] y;
        int            acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          w_valid;
    logic          w_ready;
    logic [VW-1:0] w_data;
    logic          w_signed;
    logic          a_valid;
    logic          a_ready;
    logic [VW-1:0] a_data;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          busy;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   last_acc = 0;
    int   last_beat = 0;

    systolic_mmu #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ARRAY_SIZE(N)) dut (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_signed(w_signed),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .out_valid(out_valid), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [VW-1:0] rep_x(input logic [DW-1:0] v);
        logic [VW-1:0] r;
        for (int j = 0; j < N; j++) r[j*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [OW-1:0] rep_y(input logic [AW-1:0] v);
        logic [OW-1:0] r;
        for (int j = 0; j < N; j++) r[j*AW +: AW] = v;
        return r;
    endfunction

    function automatic wmat_t rep_w(input logic [DW-1:0] v);
        wmat_t m;
        for (int k = 0; k < N; k++) m[k] = rep_x(v);
        return m;
    endfunction

    function automatic wmat_t ident();
        wmat_t m;
        for (int k = 0; k < N; k++) m[k] = VW'(1) << (k * DW);
        return m;
    endfunction

    function automatic logic [VW-1:0] vec(input logic [7:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [OW-1:0] ovec(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one line per result, compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", OW'(1), OW'(0));
            end else begin
                mon_e = sb.pop_front();
                $display("out   cycle %0d y=%h", cyc, out_data);
                chk("out_data", out_data, mon_e.y);
                chk("latency", OW'(cyc - mon_e.acc), OW'(2 * N));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        w_valid = 1'b0;
        a_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst_w_ready", OW'(w_ready), OW'(0));
        chk("rst_a_ready", OW'(a_ready), OW'(0));
        tick();
        @(negedge clk);
        chk("rst_out_valid", OW'(out_valid), OW'(0));
        chk("rst_busy", OW'(busy), OW'(0));
        chk("rst_out_data", out_data, OW'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_w_ready", OW'(w_ready), OW'(1));
        chk("post_rst_a_ready", OW'(a_ready), OW'(0));
        tick();
    endtask

    task automatic load_bank(input wmat_t wm, input logic sgn, input bit gaps, input bit toggle, input int beats);
        int n;
        for (int k = 0; k < beats; k++) begin
            n = 0;
            w_valid  = 1'b1;
            w_data   = wm[k];
            w_signed = (toggle && k > 0) ? !sgn : sgn;
            @(negedge clk);
            while (!w_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!w_ready) chk("w_ready_timeout", OW'(w_ready), OW'(1));
            last_beat = cyc;
            $display("wbeat cycle %0d row %0d data=%h signed=%0b", cyc, k, w_data, w_signed);
            tick();
            w_valid = 1'b0;
            if (gaps && k < beats - 1) tick();
        end
    endtask

    task automatic send_vec(input logic [VW-1:0] x, input logic [OW-1:0] y);
        int n;
        n = 0;
        a_valid = 1'b1;
        a_data  = x;
        @(negedge clk);
        while (!a_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!a_ready) begin
            chk("a_ready_timeout", OW'(a_ready), OW'(1));
            a_valid = 1'b0;
            tick();
            return;
        end
        sb.push_back('{y: y, acc: cyc});
        last_acc = cyc;
        $display("in    cycle %0d x=%h", cyc, x);
        tick();
        a_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_pending", OW'(sb.size()), OW'(0));
        chk("idle_busy", OW'(busy), OW'(0));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lastA;
        int first_acc;
        int ov;
        rst = 1'b1; w_valid = 1'b0; a_valid = 1'b0;
        w_data = '0; a_data = '0; w_signed = 1'b0;
        tick();
        do_reset();

        // Identity, unsigned, with load-to-use timing.
        load_bank(ident(), 1'b0, 1'b0, 1'b0, N);
        @(negedge clk);
        chk("load_t1_a_ready", OW'(a_ready), OW'(0));
        tick();
        @(negedge clk);
        chk("load_t2_a_ready", OW'(a_ready), OW'(1));
        chk("load_t2_w_ready", OW'(w_ready), OW'(1));
        tick();
        send_vec(vec(1, 2, 3, 4), ovec(1, 2, 3, 4));
        @(negedge clk);
        chk("busy_in_flight", OW'(busy), OW'(1));
        tick();
        wait_idle();

        // Signed and unsigned corners.
        load_bank(rep_w(8'h80), 1'b1, 1'b0, 1'b0, N);
        send_vec(rep_x(8'h80), rep_y(32'd65536));
        send_vec(vec(1, 2, 3, 4), rep_y(32'hFFFF_FB00));
        wait_idle();
        load_bank(rep_w(8'h80), 1'b0, 1'b0, 1'b0, N);
        send_vec(rep_x(8'h80), rep_y(32'd65536));
        send_vec(vec(1, 2, 3, 4), rep_y(32'd1280));
        wait_idle();
        load_bank(rep_w(8'hFF), 1'b0, 1'b0, 1'b0, N);
        send_vec(rep_x(8'hFF), rep_y(32'd260100));
        wait_idle();
        load_bank(rep_w(8'hFF), 1'b1, 1'b0, 1'b0, N);
        send_vec(vec(1, 2, 3, 4), rep_y(32'hFFFF_FFF6));
        send_vec(rep_x(8'hFF), rep_y(32'd4));
        wait_idle();

        // Gapped load, sign only from beat 0, extra beat refused while shadow is full.
        load_bank(rep_w(8'hFF), 1'b0, 1'b1, 1'b1, N);
        w_valid = 1'b1;
        w_data  = rep_x(8'h05);
        @(negedge clk);
        chk("fifth_beat_w_ready", OW'(w_ready), OW'(0));
        tick();
        w_valid = 1'b0;
        @(negedge clk);
        chk("after_swap_w_ready", OW'(w_ready), OW'(1));
        chk("after_swap_a_ready", OW'(a_ready), OW'(1));
        tick();
        send_vec(vec(1, 2, 3, 4), rep_y(32'd2550));
        wait_idle();

        // Streaming 16 back-to-back vectors.
        load_bank(rep_w(8'h01), 1'b0, 1'b0, 1'b0, N);
        first_acc = 0;
        for (int k = 1; k <= 16; k++) begin
            send_vec(rep_x(8'(k)), rep_y(32'(4 * k)));
            if (k == 1) first_acc = last_acc;
        end
        chk("stream_back_to_back", OW'(last_acc - first_acc), OW'(15));
        wait_idle();

        // Reload bank B (all 2) while bank A (all 1) streams.
        fork
            begin
                for (int k = 1; k <= 5; k++) send_vec(rep_x(8'(k)), rep_y(32'(4 * k)));
            end
            begin
                tick();
                tick();
                load_bank(rep_w(8'h02), 1'b0, 1'b0, 1'b0, N);
            end
        join
        lastA = last_acc;
        @(negedge clk);
        chk("reload_a_ready_drop", OW'(a_ready), OW'(0));
        chk("reload_busy", OW'(busy), OW'(1));
        tick();
        send_vec(rep_x(8'd1), rep_y(32'd8));
        chk("reload_swap_to_accept", OW'(last_acc - lastA), OW'(2 * N + 2));
        send_vec(rep_x(8'd2), rep_y(32'd16));
        send_vec(rep_x(8'd3), rep_y(32'd24));
        wait_idle();

        // Reset with vectors in flight and a partial load.
        for (int k = 1; k <= 3; k++) send_vec(rep_x(8'(k)), rep_y(32'(8 * k)));
        load_bank(rep_w(8'h03), 1'b0, 1'b0, 1'b0, 2);
        do_reset();
        ov = 0;
        a_valid = 1'b1;
        a_data  = rep_x(8'h09);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            ov += int'(out_valid);
            if (k == 11) chk("post_rst_no_accept", OW'(a_ready), OW'(0));
            tick();
        end
        a_valid = 1'b0;
        chk("post_rst_no_out_valid", OW'(ov), OW'(0));
        load_bank(ident(), 1'b0, 1'b0, 1'b0, N);
        send_vec(vec(5, 6, 7, 8), ovec(5, 6, 7, 8));
        wait_idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
